sisc_exec_ctrl: RTL and testbench

Execution core of the SISC multicycle processor: the control state machine, the 32-bit ALU and the branch-address adder combined in one block. It sits between the instruction register, register file, status register, program counter and data memory. It sequences fetch/decode/execute/mem/writeback, computes ALU results and status flags, and produces branch targets and every datapath control strobe.

---
 rtl/sisc_exec_ctrl_pkg.sv | 58 +++++
 rtl/sisc_alu.sv | 51 +++++
 rtl/sisc_exec_ctrl.sv | 153 +++++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_exec_ctrl_pkg.sv
// rtl/sisc_exec_ctrl_pkg.sv - shared opcodes, ALU codes, state encoding and decode helpers
package sisc_exec_ctrl_pkg;

    localparam logic [3:0] OP_NOOP   = 4'b0000;
    localparam logic [3:0] OP_REG_OP = 4'b0001;
    localparam logic [3:0] OP_REG_IM = 4'b0010;
    localparam logic [3:0] OP_BRA    = 4'b0100;
    localparam logic [3:0] OP_BRR    = 4'b0101;
    localparam logic [3:0] OP_BNE    = 4'b0110;
    localparam logic [3:0] OP_BNR    = 4'b0111;
    localparam logic [3:0] OP_LOD    = 4'b1010;
    localparam logic [3:0] OP_STR    = 4'b1011;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic [3:0] FN_ADD  = 4'b0001;
    localparam logic [3:0] FN_SUB  = 4'b0010;
    localparam logic [3:0] FN_NOT  = 4'b0011;
    localparam logic [3:0] FN_OR   = 4'b0100;
    localparam logic [3:0] FN_AND  = 4'b0101;
    localparam logic [3:0] FN_XOR  = 4'b0110;
    localparam logic [3:0] FN_ROTR = 4'b0111;
    localparam logic [3:0] FN_ROTL = 4'b1000;
    localparam logic [3:0] FN_SHL  = 4'b1001;
    localparam logic [3:0] FN_SHR  = 4'b1010;

    localparam logic [1:0] ALUOP_REG  = 2'b00;
    localparam logic [1:0] ALUOP_IMM  = 2'b01;
    localparam logic [1:0] ALUOP_ADDR = 2'b11;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        S_START0,
        S_START1,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOD) || (op == OP_STR);
    endfunction

    function automatic logic [1:0] decode_alu_op(input logic [3:0] op, input logic [3:0] mm);
        if (op == OP_REG_IM)
            return ALUOP_IMM;
        else if (is_mem_op(op) && mm[0])
            return ALUOP_ADDR;
        else
            return ALUOP_REG;
    endfunction

endpackage

// File: rtl/sisc_alu.sv
// rtl/sisc_alu.sv - combinational 32-bit ALU producing result and {C,V,N,Z}
module sisc_alu
    import sisc_exec_ctrl_pkg::*;
(
    input  logic [3:0]  i_func,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic [3:0]  o_stat
);

    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [4:0]  w_shamt;
    logic [5:0]  w_rshamt;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff   = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
    assign w_shamt  = i_b[4:0];
    // A complementary shift of 32 yields zero, so a rotate by 0 degenerates cleanly.
    assign w_rshamt = 6'd32 - {1'b0, w_shamt};

    always_comb begin
        o_result = 32'd0;
        o_stat   = 4'd0;
        case (i_func)
            FN_ADD: begin
                o_result       = w_sum[31:0];
                o_stat[FLAG_C] = w_sum[32];
                o_stat[FLAG_V] = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            FN_SUB: begin
                o_result       = w_diff[31:0];
                o_stat[FLAG_C] = w_diff[32];
                o_stat[FLAG_V] = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            FN_NOT:  o_result = ~i_a;
            FN_OR:   o_result = i_a | i_b;
            FN_AND:  o_result = i_a & i_b;
            FN_XOR:  o_result = i_a ^ i_b;
            FN_ROTR: o_result = (i_a >> w_shamt) | (i_a << w_rshamt);
            FN_ROTL: o_result = (i_a << w_shamt) | (i_a >> w_rshamt);
            FN_SHL:  o_result = i_a << w_shamt;
            FN_SHR:  o_result = i_a >> w_shamt;
            default: o_result = 32'd0;
        endcase
        o_stat[FLAG_N] = o_result[31];
        o_stat[FLAG_Z] = (o_result == 32'd0);
    end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// rtl/sisc_exec_ctrl.sv - SISC control FSM, ALU wrapper and branch-address adder
module sisc_exec_ctrl
    import sisc_exec_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] ir,
    input  logic [3:0]  srout,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [15:0] pc_out,
    output logic [31:0] alu_result,
    output logic [3:0]  stat,
    output logic        stat_en,
    output logic [15:0] br_addr,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        rb_sel,
    output logic        mm_sel,
    output logic        dm_we,
    output logic [1:0]  alu_op,
    output logic        pc_rst,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        br_sel,
    output logic        ir_load
);

    state_t      r_state;
    logic        r_pc_rst;
    logic        r_ir_load;
    logic        r_fetch_pcw;
    logic        r_stat_en;
    logic        r_rf_we;
    logic        r_wb_sel;
    logic        r_rb_sel;
    logic        r_mm_sel;
    logic        r_dm_we;
    logic [1:0]  r_alu_op;

    logic [3:0]  w_opcode;
    logic [3:0]  w_mm;
    logic [15:0] w_imm;
    logic [31:0] w_imm_sext;
    logic        w_in_decode;
    logic        w_cond;
    logic        w_taken;
    logic        w_br_sel;
    logic [3:0]  w_func;
    logic [31:0] w_b;
    logic        w_unused_ir;

    assign w_opcode    = ir[31:28];
    assign w_mm        = ir[27:24];
    assign w_imm       = ir[15:0];
    assign w_imm_sext  = {{16{w_imm[15]}}, w_imm};
    assign w_unused_ir = ^ir[23:16];

    // Branch strobes depend on the freshly loaded IR, so they are decoded from the DECODE state.
    assign w_in_decode = (r_state == S_DECODE);
    assign w_cond      = |(w_mm & srout);
    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            OP_BRA, OP_BRR: w_taken = w_cond;
            OP_BNE, OP_BNR: w_taken = !w_cond;
            default:        w_taken = 1'b0;
        endcase
    end
    assign w_br_sel = w_in_decode && ((w_opcode == OP_BRR) || (w_opcode == OP_BNR));
    assign br_addr  = w_br_sel ? (pc_out + w_imm) : w_imm;

    assign w_func = r_alu_op[1] ? FN_ADD : ((w_opcode == OP_REG_IM) ? w_mm : ir[3:0]);
    assign w_b    = r_alu_op[0] ? w_imm_sext : rsb;

    sisc_alu u_alu (
        .i_func   (w_func),
        .i_a      (rsa),
        .i_b      (w_b),
        .o_result (alu_result),
        .o_stat   (stat)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state     <= S_START0;
            r_pc_rst    <= 1'b1;
            r_ir_load   <= 1'b0;
            r_fetch_pcw <= 1'b0;
            r_stat_en   <= 1'b0;
            r_rf_we     <= 1'b0;
            r_wb_sel    <= 1'b0;
            r_rb_sel    <= 1'b0;
            r_mm_sel    <= 1'b0;
            r_dm_we     <= 1'b0;
            r_alu_op    <= ALUOP_REG;
        end else begin
            r_pc_rst    <= 1'b0;
            r_ir_load   <= 1'b0;
            r_fetch_pcw <= 1'b0;
            r_stat_en   <= 1'b0;
            r_rf_we     <= 1'b0;
            r_wb_sel    <= 1'b0;
            r_dm_we     <= 1'b0;
            case (r_state)
                S_START0: r_state <= S_START1;
                S_START1, S_WRITEBACK: begin
                    r_state     <= S_FETCH;
                    r_ir_load   <= 1'b1;
                    r_fetch_pcw <= 1'b1;
                    r_alu_op    <= ALUOP_REG;
                    r_mm_sel    <= 1'b0;
                    r_rb_sel    <= 1'b0;
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_opcode != OP_HLT) begin
                        r_state   <= S_EXECUTE;
                        r_alu_op  <= decode_alu_op(w_opcode, w_mm);
                        r_mm_sel  <= is_mem_op(w_opcode) && !w_mm[0];
                        r_rb_sel  <= (w_opcode == OP_STR);
                        r_stat_en <= (w_opcode == OP_REG_OP) || (w_opcode == OP_REG_IM);
                    end
                end
                S_EXECUTE: begin
                    r_state <= S_MEM;
                    r_dm_we <= (w_opcode == OP_STR);
                end
                S_MEM: begin
                    r_state  <= S_WRITEBACK;
                    r_rf_we  <= (w_opcode == OP_REG_OP) || (w_opcode == OP_REG_IM) ||
                                (w_opcode == OP_LOD);
                    r_wb_sel <= (w_opcode == OP_LOD);
                end
                default: r_state <= S_START0;
            endcase
        end
    end

    assign pc_rst   = r_pc_rst;
    assign ir_load  = r_ir_load;
    assign pc_write = r_fetch_pcw | (w_in_decode & w_taken);
    assign pc_sel   = w_in_decode & w_taken;
    assign br_sel   = w_br_sel;
    assign stat_en  = r_stat_en;
    assign rf_we    = r_rf_we;
    assign wb_sel   = r_wb_sel;
    assign rb_sel   = r_rb_sel;
    assign mm_sel   = r_mm_sel;
    assign dm_we    = r_dm_we;
    assign alu_op   = r_alu_op;

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb/tb_sisc_exec_ctrl.sv - scoreboard bench for sisc_exec_ctrl with directed instructions
module tb_sisc_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic [31:0] ir = 32'd0;
    logic [3:0]  srout = 4'd0;
    logic [31:0] rsa = 32'd0;
    logic [31:0] rsb = 32'd0;
    logic [15:0] pc_out = 16'd0;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic        stat_en, rf_we, wb_sel, rb_sel, mm_sel, dm_we;
    logic [1:0]  alu_op;
    logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic [15:0] br_addr;

    sisc_exec_ctrl dut (
        .clk(clk), .rst_f(rst_f), .ir(ir), .srout(srout), .rsa(rsa), .rsb(rsb),
        .pc_out(pc_out), .alu_result(alu_result), .stat(stat), .stat_en(stat_en),
        .br_addr(br_addr), .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel),
        .mm_sel(mm_sel), .dm_we(dm_we), .alu_op(alu_op), .pc_rst(pc_rst),
        .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Control vector: {pc_rst,pc_write,pc_sel,br_sel,ir_load,stat_en,rf_we,wb_sel,rb_sel,mm_sel,dm_we,alu_op}
    localparam logic [12:0] NONE  = 13'h0000;
    localparam logic [12:0] PCRST = 13'h1000;
    localparam logic [12:0] PCW   = 13'h0800;
    localparam logic [12:0] PCSEL = 13'h0400;
    localparam logic [12:0] BRSEL = 13'h0200;
    localparam logic [12:0] IRL   = 13'h0100;
    localparam logic [12:0] STEN  = 13'h0080;
    localparam logic [12:0] RFWE  = 13'h0040;
    localparam logic [12:0] WBSEL = 13'h0020;
    localparam logic [12:0] RBSEL = 13'h0010;
    localparam logic [12:0] MMSEL = 13'h0008;
    localparam logic [12:0] DMWE  = 13'h0004;
    localparam logic [12:0] AIMM  = 13'h0001;
    localparam logic [12:0] AADR  = 13'h0003;

    typedef struct {
        int          cyc;
        string       name;
        logic [12:0] ctrl;
        bit          chk_res;
        logic [31:0] res;
        bit          chk_stat;
        logic [3:0]  st;
        bit          chk_br;
        logic [15:0] br;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s @cycle %0d: got 0x%0h, expected 0x%0h", nm, fld, cyc, act, req);
        end
    endtask

    task automatic expect_at(input string nm, input int offs, input logic [12:0] c,
                             input logic [2:0] chk, input logic [31:0] res,
                             input logic [3:0] st, input logic [15:0] br);
        exp_t e;
        e.cyc = cyc + offs; e.name = nm; e.ctrl = c;
        e.chk_res = chk[2]; e.res = res;
        e.chk_stat = chk[1]; e.st = st;
        e.chk_br = chk[0]; e.br = br;
        q.push_back(e);
    endtask

    exp_t        m_e;
    logic [12:0] m_act;
    always @(negedge clk) begin
        m_act = {pc_rst, pc_write, pc_sel, br_sel, ir_load, stat_en, rf_we, wb_sel,
                 rb_sel, mm_sel, dm_we, alu_op};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            if (m_e.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", m_e.name, m_e.cyc, cyc);
            end else begin
                check(m_e.name, "ctrl", {19'd0, m_act}, {19'd0, m_e.ctrl});
                if (m_e.chk_res)  check(m_e.name, "alu_result", alu_result, m_e.res);
                if (m_e.chk_stat) check(m_e.name, "stat", {28'd0, stat}, {28'd0, m_e.st});
                if (m_e.chk_br)   check(m_e.name, "br_addr", {16'd0, br_addr}, {16'd0, m_e.br});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle into FETCH after reset release.
    task automatic do_reset();
        rst_f = 1'b0;
        tick();
        expect_at("reset", 0, PCRST, 3'b000, 32'd0, 4'd0, 16'd0);
        tick();
        expect_at("reset_hold", 0, PCRST, 3'b000, 32'd0, 4'd0, 16'd0);
        rst_f = 1'b1;
        tick();
        expect_at("start1", 0, NONE, 3'b000, 32'd0, 4'd0, 16'd0);
        tick();
    endtask

    task automatic run_instr(input string nm, input logic [31:0] i_ir, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] sr, input logic [15:0] pc,
                             input logic [12:0] d_c, input logic [12:0] e_c,
                             input logic [12:0] m_c, input logic [12:0] w_c,
                             input logic [2:0] chk, input logic [31:0] res,
                             input logic [3:0] st, input logic [15:0] br);
        ir = i_ir; rsa = a; rsb = b; srout = sr; pc_out = pc;
        expect_at({nm, "_fetch"}, 0, IRL | PCW, 3'b000, 32'd0, 4'd0, 16'd0);
        expect_at({nm, "_decode"}, 1, d_c, {2'b00, chk[0]}, 32'd0, 4'd0, br);
        expect_at({nm, "_exec"}, 2, e_c, {chk[2:1], 1'b0}, res, st, 16'd0);
        expect_at({nm, "_mem"}, 3, m_c, {chk[2], 2'b00}, res, st, 16'd0);
        expect_at({nm, "_wb"}, 4, w_c, {chk[2], 2'b00}, res, st, 16'd0);
        repeat (5) tick();
    endtask

    initial begin
        do_reset();
        run_instr("add_ovf", 32'h1012_3001, 32'h7FFF_FFFF, 32'h0000_0001, 4'h0, 16'h0000,
                  NONE, STEN, NONE, RFWE, 3'b110, 32'h8000_0000, 4'b0110, 16'd0);
        run_instr("subi_zero", 32'h2212_0005, 32'h0000_0005, 32'h0000_1234, 4'h0, 16'h0000,
                  NONE, STEN | AIMM, AIMM, RFWE | AIMM, 3'b110, 32'h0, 4'b1001, 16'd0);
        run_instr("sub_borrow", 32'h1012_3002, 32'h0, 32'h1, 4'h0, 16'h0000,
                  NONE, STEN, NONE, RFWE, 3'b110, 32'hFFFF_FFFF, 4'b0010, 16'd0);
        run_instr("rotr", 32'h1012_3007, 32'h0000_00F1, 32'h4, 4'h0, 16'h0000,
                  NONE, STEN, NONE, RFWE, 3'b110, 32'h1000_000F, 4'b0000, 16'd0);
        run_instr("rotl", 32'h1012_3008, 32'h8000_0001, 32'h1, 4'h0, 16'h0000,
                  NONE, STEN, NONE, RFWE, 3'b110, 32'h0000_0003, 4'b0000, 16'd0);
        run_instr("shli", 32'h2912_001F, 32'h0000_0001, 32'h0, 4'h0, 16'h0000,
                  NONE, STEN | AIMM, AIMM, RFWE | AIMM, 3'b110, 32'h8000_0000, 4'b0010, 16'd0);
        run_instr("bad_fn", 32'h1012_300F, 32'h5, 32'h6, 4'h0, 16'h0000,
                  NONE, STEN, NONE, RFWE, 3'b110, 32'h0, 4'b0001, 16'd0);
        run_instr("brr_taken", 32'h5100_FFFE, 32'h0, 32'h0, 4'b0001, 16'h0010,
                  BRSEL | PCW | PCSEL, NONE, NONE, NONE, 3'b001, 32'd0, 4'd0, 16'h000E);
        run_instr("brr_not", 32'h5100_FFFE, 32'h0, 32'h0, 4'b0000, 16'h0010,
                  BRSEL, NONE, NONE, NONE, 3'b001, 32'd0, 4'd0, 16'h000E);
        run_instr("bne_taken", 32'h6100_1234, 32'h0, 32'h0, 4'b0010, 16'h0040,
                  PCW | PCSEL, NONE, NONE, NONE, 3'b001, 32'd0, 4'd0, 16'h1234);
        run_instr("bra_not", 32'h4C00_0020, 32'h0, 32'h0, 4'b0011, 16'h0040,
                  NONE, NONE, NONE, NONE, 3'b001, 32'd0, 4'd0, 16'h0020);
        run_instr("lod_rel", 32'hA112_0004, 32'h0000_0010, 32'h0, 4'h0, 16'h0000,
                  NONE, AADR, AADR, RFWE | WBSEL | AADR, 3'b110, 32'h0000_0014, 4'b0000, 16'd0);
        run_instr("lod_abs", 32'hA012_0080, 32'h0000_0010, 32'h0, 4'h0, 16'h0000,
                  NONE, MMSEL, MMSEL, RFWE | WBSEL | MMSEL, 3'b000, 32'd0, 4'd0, 16'd0);
        run_instr("str_abs", 32'hB012_0040, 32'h0000_0010, 32'h0000_ABCD, 4'h0, 16'h0000,
                  NONE, MMSEL | RBSEL, MMSEL | RBSEL | DMWE, MMSEL | RBSEL, 3'b000, 32'd0, 4'd0, 16'd0);

        // HLT parks in DECODE; only reset brings it back.
        ir = 32'hF000_0000;
        expect_at("hlt_fetch", 0, IRL | PCW, 3'b000, 32'd0, 4'd0, 16'd0);
        for (int i = 1; i <= 20; i++)
            expect_at("hlt_decode", i, NONE, 3'b000, 32'd0, 4'd0, 16'd0);
        repeat (21) tick();
        do_reset();

        // Reset asserted mid-EXECUTE must take effect before the next clock edge.
        ir = 32'h1012_3001; rsa = 32'h1; rsb = 32'h2;
        expect_at("abort_fetch", 0, IRL | PCW, 3'b000, 32'd0, 4'd0, 16'd0);
        expect_at("abort_decode", 1, NONE, 3'b000, 32'd0, 4'd0, 16'd0);
        expect_at("abort_exec", 2, PCRST, 3'b000, 32'd0, 4'd0, 16'd0);
        tick();
        tick();
        rst_f = 1'b0;
        tick();
        expect_at("abort_start0", 0, PCRST, 3'b000, 32'd0, 4'd0, 16'd0);
        rst_f = 1'b1;
        tick();
        expect_at("abort_start1", 0, NONE, 3'b000, 32'd0, 4'd0, 16'd0);
        tick();
        run_instr("xor_after", 32'h1012_3006, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'h0, 16'h0000,
                  NONE, STEN, NONE, RFWE, 3'b110, 32'h0, 4'b0001, 16'd0);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        while (q.size() > 0) begin
            m_e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never reached", m_e.name, m_e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
